// File: rtl/acondicionador_botones.sv
// Push-button conditioning: per-lane 2-FF synchroniser, counter debounce,
// single-cycle press pulse and long-press pulse for the pet mode controller.
module acondicionador_botones #(
    parameter int unsigned N_BOTONES         = 3,
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter int unsigned LONG_PRESS_CYCLES = 250000000,
    parameter int unsigned ACTIVE_LOW        = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BOTONES-1:0] btn_raw,
    output logic [N_BOTONES-1:0] btn_level,
    output logic [N_BOTONES-1:0] btn_press,
    output logic [N_BOTONES-1:0] btn_long
);

    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;

    localparam logic [DEB_W-1:0]     DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]    HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [N_BOTONES-1:0] RAW_MASK = (ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        REPOSO,
        PRESIONADO,
        LARGO
    } estado_t;

    logic [N_BOTONES-1:0]             pressed_raw;
    logic [N_BOTONES-1:0]             sync1_q;
    logic [N_BOTONES-1:0]             sync2_q;
    logic [N_BOTONES-1:0][DEB_W-1:0]  deb_cnt_q;
    logic [N_BOTONES-1:0][DEB_W-1:0]  deb_cnt_d;
    logic [N_BOTONES-1:0]             level_q;
    logic [N_BOTONES-1:0]             level_d;
    logic [N_BOTONES-1:0][HOLD_W-1:0] hold_cnt_q;
    logic [N_BOTONES-1:0][HOLD_W-1:0] hold_cnt_d;
    logic [N_BOTONES-1:0]             press_q;
    logic [N_BOTONES-1:0]             press_d;
    logic [N_BOTONES-1:0]             long_q;
    logic [N_BOTONES-1:0]             long_d;
    estado_t                          estado_q [N_BOTONES];
    estado_t                          estado_d [N_BOTONES];

    // Normalised so that 1 = pressed; the synchroniser resets to "not pressed".
    assign pressed_raw = btn_raw ^ RAW_MASK;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_cnt_q  <= '0;
            level_q    <= '0;
            hold_cnt_q <= '0;
            press_q    <= '0;
            long_q     <= '0;
            for (int unsigned i = 0; i < N_BOTONES; i++) begin
                estado_q[i] <= REPOSO;
            end
        end else begin
            sync1_q    <= pressed_raw;
            sync2_q    <= sync1_q;
            deb_cnt_q  <= deb_cnt_d;
            level_q    <= level_d;
            hold_cnt_q <= hold_cnt_d;
            press_q    <= press_d;
            long_q     <= long_d;
            for (int unsigned i = 0; i < N_BOTONES; i++) begin
                estado_q[i] <= estado_d[i];
            end
        end
    end

    // Any single cycle of agreement clears the count, so short glitches vanish.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        level_d   = level_q;
        for (int unsigned i = 0; i < N_BOTONES; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_MAX) begin
                level_d[i]   = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    // The FSM reacts to the next debounced level so that btn_press is
    // registered on the same edge that raises btn_level.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        press_d    = '0;
        long_d     = '0;
        for (int unsigned i = 0; i < N_BOTONES; i++) begin
            estado_d[i] = estado_q[i];
            case (estado_q[i])
                REPOSO: begin
                    if (level_d[i] && !level_q[i]) begin
                        press_d[i]    = 1'b1;
                        hold_cnt_d[i] = '0;
                        estado_d[i]   = PRESIONADO;
                    end
                end
                PRESIONADO: begin
                    if (!level_d[i]) begin
                        hold_cnt_d[i] = '0;
                        estado_d[i]   = REPOSO;
                    end else if (hold_cnt_q[i] == HOLD_MAX) begin
                        long_d[i]   = 1'b1;
                        estado_d[i] = LARGO;
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + HOLD_W'(1);
                    end
                end
                LARGO: begin
                    if (!level_d[i]) begin
                        hold_cnt_d[i] = '0;
                        estado_d[i]   = REPOSO;
                    end
                end
                default: begin
                    hold_cnt_d[i] = '0;
                    estado_d[i]   = REPOSO;
                end
            endcase
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign btn_long  = long_q;

endmodule

// File: tb/tb_acondicionador_botones.sv
// Scoreboard bench for acondicionador_botones with short debounce/long-press
// counts; expected outputs are queued per cycle as stimulus is scheduled.
module tb_acondicionador_botones;

    localparam int N   = 3;
    localparam int D   = 4;
    localparam int L   = 20;
    localparam int LAT = 2 + D;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] btn_raw = '1;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_long;

    typedef struct packed {
        logic [N-1:0] lvl;
        logic [N-1:0] prs;
        logic [N-1:0] lng;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    acondicionador_botones #(
        .N_BOTONES        (N),
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .ACTIVE_LOW       (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_long (btn_long)
    );

    task automatic check_val(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, got, want, $time);
        end
    endtask

    // Drive raw pins, advance one edge, compare against the oldest expectation.
    task automatic step(input logic [N-1:0] raw);
        exp_t e;
        btn_raw = raw;
        @(posedge clk);
        #1;
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        check_val("level", btn_level, e.lvl);
        check_val("press", btn_press, e.prs);
        check_val("long", btn_long, e.lng);
    endtask

    task automatic push_idle(input int t);
        for (int j = 1; j <= t; j++) exp_q.push_back('0);
    endtask

    // Press lanes in mask for h edges, observe t edges from the first press edge.
    task automatic run_press(input logic [N-1:0] mask, input int h, input int t);
        for (int j = 1; j <= t; j++) begin
            exp_t e;
            e.lvl = (j >= LAT && j <= h + LAT - 1) ? mask : '0;
            e.prs = (j == LAT) ? mask : '0;
            e.lng = (j == LAT + L && h >= L + 1) ? mask : '0;
            exp_q.push_back(e);
        end
        for (int j = 1; j <= t; j++) step((j <= h) ? ~mask : '1);
    endtask

    initial begin
        #1;
        check_val("rst_level", btn_level, '0);
        check_val("rst_press", btn_press, '0);
        check_val("rst_long", btn_long, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        push_idle(5);
        for (int j = 0; j < 5; j++) step('1);

        // Clean press on lane 0
        run_press(3'b001, 10, 20);

        // Two 3-cycle bursts on lane 1 must never be accepted
        push_idle(16);
        for (int j = 1; j <= 16; j++) step((j <= 3 || (j >= 5 && j <= 7)) ? 3'b101 : 3'b111);

        // Long press on lane 2, no auto-repeat
        run_press(3'b100, 40, 50);

        // Short press, then a fresh press
        run_press(3'b001, 15, 25);
        run_press(3'b001, 10, 20);

        // Release one cycle before / exactly at the long-press threshold
        run_press(3'b010, L, L + 12);
        run_press(3'b010, L + 1, L + 12);

        // All lanes together
        run_press(3'b111, 30, 40);

        // Reset while lane 0 is held with hold count at 10
        begin
            exp_t e;
            for (int j = 1; j <= LAT + 10; j++) begin
                e.lvl = (j >= LAT) ? 3'b001 : 3'b000;
                e.prs = (j == LAT) ? 3'b001 : 3'b000;
                e.lng = '0;
                exp_q.push_back(e);
            end
        end
        for (int j = 1; j <= LAT + 10; j++) step(3'b110);
        reset = 1'b0;
        #1;
        check_val("async_rst_level", btn_level, '0);
        check_val("async_rst_press", btn_press, '0);
        check_val("async_rst_long", btn_long, '0);
        push_idle(2);
        for (int j = 0; j < 2; j++) step(3'b110);
        reset = 1'b1;
        run_press(3'b001, 30, 40);

        push_idle(5);
        for (int j = 0; j < 5; j++) step('1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
